// File: rtl/sd_spi_engine.sv
// SPI mode-0 byte engine for an SD card socket: one byte per start pulse,
// software chip-select, and a synchronized, debounced card-detect.
//
// state | meaning
// IDLE  | waiting for start_wr / start_rd
// LOW   | SCK low, current bit on MOSI, H cycles
// HIGH  | SCK high, MISO captured on entry, H cycles
// DONE  | one cycle: rx_data updated, rx_valid pulsed, new start accepted
module sd_spi_engine #(
  parameter int SLOW_HALF  = 35,
  parameter int FAST_HALF  = 2,
  parameter int DEB_CYCLES = 28000
) (
  input  logic       clk28,
  input  logic       rst,
  input  logic       start_wr,
  input  logic       start_rd,
  input  logic [7:0] tx_data,
  input  logic       fast,
  input  logic       cs_wr,
  input  logic       cs_val,
  input  logic       cd_ack,
  input  logic       sd_miso,
  input  logic       sd_cd,
  output logic       sd_sck,
  output logic       sd_mosi,
  output logic       sd_cs,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       cd_stable,
  output logic       cd_changed
);

  localparam int HMAX = (SLOW_HALF > FAST_HALF) ? SLOW_HALF : FAST_HALF;
  localparam int HW   = (HMAX > 1) ? $clog2(HMAX) : 1;
  localparam int DW   = $clog2(DEB_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t        state, state_nxt;
  logic [HW-1:0] half_cnt, half_lim;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          mosi_bit;
  logic          half_end, start;

  assign half_end = (half_cnt == half_lim);
  assign start    = ((state == IDLE) || (state == DONE)) && (start_wr || start_rd);

  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? LOW : IDLE;
      LOW:     if (half_end) state_nxt = HIGH;
      HIGH:    if (half_end) state_nxt = (bit_cnt == 3'd7) ? DONE : LOW;
      DONE:    state_nxt = start ? LOW : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sd_sck   = (state == HIGH);
    busy     = (state == LOW) || (state == HIGH);
    sd_mosi  = busy ? mosi_bit : 1'b1;
    rx_valid = (state == DONE);
  end

  // mosi_bit only changes on entry to LOW, so MOSI never moves while SCK is high
  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      half_cnt <= '0;
      half_lim <= '0;
      bit_cnt  <= '0;
      shift    <= 8'hFF;
      mosi_bit <= 1'b1;
      rx_data  <= 8'hFF;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          shift    <= start_wr ? tx_data : 8'hFF;
          mosi_bit <= start_wr ? tx_data[7] : 1'b1;
          half_lim <= fast ? HW'(FAST_HALF - 1) : HW'(SLOW_HALF - 1);
          half_cnt <= '0;
          bit_cnt  <= '0;
        end
        LOW: if (half_end) begin
          half_cnt <= '0;
          shift    <= {shift[6:0], sd_miso};
        end else begin
          half_cnt <= half_cnt + 1'b1;
        end
        HIGH: if (half_end) begin
          half_cnt <= '0;
          if (bit_cnt == 3'd7) begin
            rx_data <= shift;
          end else begin
            bit_cnt  <= bit_cnt + 3'd1;
            mosi_bit <= shift[7];
          end
        end else begin
          half_cnt <= half_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk28 or posedge rst) begin
    if (rst)        sd_cs <= 1'b1;
    else if (cs_wr) sd_cs <= cs_val;
  end

  logic          cd_meta, cd_sync, cd_set;
  logic [DW-1:0] deb_cnt;

  assign cd_set = (cd_sync != cd_stable) && (deb_cnt == DW'(DEB_CYCLES - 1));

  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      cd_meta    <= 1'b0;
      cd_sync    <= 1'b0;
      deb_cnt    <= '0;
      cd_stable  <= 1'b0;
      cd_changed <= 1'b0;
    end else begin
      cd_meta <= sd_cd;
      cd_sync <= cd_meta;
      if (cd_sync == cd_stable || cd_set) deb_cnt <= '0;
      else                                deb_cnt <= deb_cnt + 1'b1;
      if (cd_set) cd_stable <= cd_sync;
      if (cd_set)      cd_changed <= 1'b1;
      else if (cd_ack) cd_changed <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sd_spi_engine.sv
// Scoreboard bench for sd_spi_engine: random byte transfers against a byte-level
// model, plus reset, ignored-start, chip-select and card-detect scenarios.
`timescale 1ns/1ps
module tb_sd_spi_engine;

  localparam int SLOW = 35;
  localparam int FAST = 2;
  localparam int DEB  = 16;

  logic       clk28 = 1'b0;
  logic       rst = 1'b1;
  logic       start_wr = 1'b0, start_rd = 1'b0, fast = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       cs_wr = 1'b0, cs_val = 1'b1, cd_ack = 1'b0, sd_cd = 1'b0;
  logic       sd_miso;
  logic       sd_sck, sd_mosi, sd_cs, rx_valid, busy, cd_stable, cd_changed;
  logic [7:0] rx_data;

  sd_spi_engine #(.SLOW_HALF(SLOW), .FAST_HALF(FAST), .DEB_CYCLES(DEB)) dut (
    .clk28(clk28), .rst(rst), .start_wr(start_wr), .start_rd(start_rd),
    .tx_data(tx_data), .fast(fast), .cs_wr(cs_wr), .cs_val(cs_val),
    .cd_ack(cd_ack), .sd_miso(sd_miso), .sd_cd(sd_cd), .sd_sck(sd_sck),
    .sd_mosi(sd_mosi), .sd_cs(sd_cs), .rx_data(rx_data), .rx_valid(rx_valid),
    .busy(busy), .cd_stable(cd_stable), .cd_changed(cd_changed));

  always #5 clk28 = ~clk28;

  int cyc = 0;
  always @(posedge clk28) cyc++;

  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // card model: either loopback or a fixed byte presented MSB first, advanced per SCK rise
  logic       lb = 1'b1, pat_bit = 1'b1;
  logic [7:0] pat = 8'h00;
  int         pidx = 0;
  assign sd_miso = lb ? sd_mosi : pat_bit;
  always @(posedge sd_sck) begin
    if (pidx < 7) begin
      pidx++;
      pat_bit = pat[7 - pidx];
    end
  end

  typedef struct {
    logic [7:0] rx;
    logic [7:0] tx;
    int         done_cyc;
    int         busy_len;
    int         half;
  } exp_t;
  exp_t q[$];

  int         edges = 0, busy_cnt = 0, last_rise = 0;
  logic       sck_prev = 1'b0, hi_mosi = 1'b1;
  logic [7:0] mosi_acc = 8'h00;

  always @(negedge clk28) begin
    if (rst) begin
      edges = 0; busy_cnt = 0; sck_prev = 1'b0; mosi_acc = 8'h00;
    end else begin
      if (busy) busy_cnt++;
      if (sd_sck && !sck_prev) begin
        if (edges > 0 && q.size() > 0) check("sck_period", cyc - last_rise, 2 * q[0].half);
        edges++;
        last_rise = cyc;
        mosi_acc  = {mosi_acc[6:0], sd_mosi};
        hi_mosi   = sd_mosi;
      end else if (sd_sck) begin
        check("mosi_hold_sck_high", sd_mosi, hi_mosi);
      end
      sck_prev = sd_sck;
      if (rx_valid) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rx_valid: rx_data %0h with nothing pending (cycle %0d)", rx_data, cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("rx_data", rx_data, e.rx);
          check("mosi_byte", mosi_acc, e.tx);
          check("sck_edges", edges, 8);
          check("busy_len", busy_cnt, e.busy_len);
          check("done_cycle", cyc, e.done_cyc);
          check("busy_in_done", busy, 1'b0);
        end
        edges = 0; busy_cnt = 0;
      end
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk28);
  endtask

  // kind: 1 = write, 2 = read, 3 = both pulses together
  task automatic do_xfer(input int kind, input logic [7:0] tx, input logic f,
                         input logic loop, input logic [7:0] p,
                         input logic cs_mid, input logic extra, input int gap);
    int   n, h;
    exp_t e;
    logic [7:0] eff;
    n = cyc;
    h = f ? FAST : SLOW;
    eff = (kind == 2) ? 8'hFF : tx;
    lb = loop; pat = p; pidx = 0; pat_bit = p[7];
    tx_data = tx; fast = f;
    start_wr = (kind != 2);
    start_rd = (kind != 1);
    e.rx = loop ? eff : p;
    e.tx = eff;
    e.done_cyc = n + 16 * h + 1;
    e.busy_len = 16 * h;
    e.half = h;
    q.push_back(e);
    @(negedge clk28);
    start_wr = 1'b0; start_rd = 1'b0;
    if (cs_mid) begin
      wait_cyc(n + 2);
      cs_wr = 1'b1; cs_val = 1'b1;
      @(negedge clk28);
      cs_wr = 1'b0;
      check("cs_mid_high", sd_cs, 1'b1);
      cs_wr = 1'b1; cs_val = 1'b0;
      @(negedge clk28);
      cs_wr = 1'b0;
      check("cs_mid_low", sd_cs, 1'b0);
    end
    if (extra) begin
      wait_cyc(n + 5);
      start_wr = 1'b1; tx_data = ~tx;
      @(negedge clk28);
      start_wr = 1'b0;
    end
    wait_cyc(n + 16 * h + 1 + gap);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k;
    repeat (3) @(negedge clk28);
    check("rst_sck", sd_sck, 1'b0);
    check("rst_mosi", sd_mosi, 1'b1);
    check("rst_cs", sd_cs, 1'b1);
    check("rst_rx_data", rx_data, 8'hFF);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_cd_stable", cd_stable, 1'b0);
    check("rst_cd_changed", cd_changed, 1'b0);
    rst = 1'b0;
    @(negedge clk28);
    cs_wr = 1'b1; cs_val = 1'b0;
    @(negedge clk28);
    cs_wr = 1'b0;
    check("cs_write_low", sd_cs, 1'b0);

    do_xfer(1, 8'hA5, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 2);
    do_xfer(2, 8'h5A, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0);
    do_xfer(1, 8'h3C, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 0);
    do_xfer(3, 8'h12, 1'b1, 1'b0, 8'hC6, 1'b1, 1'b0, 1);

    for (int i = 0; i < 30; i++) begin
      do_xfer(int'($urandom_range(1, 3)), 8'($urandom), ($urandom_range(0, 3) != 0),
              1'($urandom), 8'($urandom), ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)));
    end
    repeat (3) @(negedge clk28);
    check("queue_drained", q.size(), 0);

    // reset during the SCK-high phase of bit 4
    n = cyc;
    lb = 1'b1; tx_data = 8'hC3; fast = 1'b1; start_wr = 1'b1;
    @(negedge clk28);
    start_wr = 1'b0;
    wait_cyc(n + 19);
    check("pre_rst_sck_high", sd_sck, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_sck", sd_sck, 1'b0);
    check("mid_rst_mosi", sd_mosi, 1'b1);
    check("mid_rst_cs", sd_cs, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_rx_data", rx_data, 8'hFF);
    repeat (2) @(negedge clk28);
    rst = 1'b0;
    repeat (40) @(negedge clk28);
    do_xfer(1, 8'hFF, 1'b1, 1'b0, 8'h81, 1'b0, 1'b0, 2);

    // card detect: 10 cycles of bounce ending low, then a clean high
    for (int i = 0; i < 10; i++) begin
      sd_cd = (i % 2 == 0);
      @(negedge clk28);
    end
    check("cd_bounce_ignored", cd_stable, 1'b0);
    sd_cd = 1'b1;
    k = 0;
    while (!cd_stable && k < 40) begin
      @(posedge clk28);
      #1 k++;
    end
    check("cd_rise_delay", k, 18);
    check("cd_changed_set", cd_changed, 1'b1);
    @(negedge clk28);
    cd_ack = 1'b1;
    @(negedge clk28);
    cd_ack = 1'b0;
    check("cd_ack_clears", cd_changed, 1'b0);

    // falling edge with cd_ack landing on the same clock as the update
    sd_cd = 1'b0;
    repeat (17) @(negedge clk28);
    check("cd_fall_not_yet", cd_stable, 1'b1);
    cd_ack = 1'b1;
    @(negedge clk28);
    cd_ack = 1'b0;
    check("cd_fall_stable", cd_stable, 1'b0);
    check("cd_set_beats_ack", cd_changed, 1'b1);
    cd_ack = 1'b1;
    @(negedge clk28);
    cd_ack = 1'b0;
    check("cd_ack_clears_2", cd_changed, 1'b0);

    repeat (3) @(negedge clk28);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
